// File: rtl/fp_pkg.sv
// Shared floating-point datapath definitions used by the float-to-int converter
// and its alignment shifter.
package fp_pkg;

  localparam int          FP_BIAS       = 127;
  localparam int          FP_EXP_MAX    = 255;
  localparam logic [31:0] INT_MAX       = 32'h7FFFFFFF;
  localparam logic [31:0] INT_MIN       = 32'h80000000;
  // -2^31 is the one float with E==31 that still fits in a signed 32-bit int.
  localparam logic [31:0] FP_NEG_2POW31 = 32'hCF000000;

  typedef enum logic [2:0] {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN, FP_OVF} fp_class_t;

  typedef enum logic {RND_RTZ, RND_RNE} rnd_mode_t;

  // Stage-1 register contents: aligned magnitude plus rounding side bits.
  typedef struct packed {
    logic      sign;
    logic [31:0] magnitude;
    logic      guard;
    logic      sticky;
    fp_class_t cls;
    rnd_mode_t rndMode;
  } align_t;

endpackage

// File: rtl/float_align_shifter.sv
// Aligns a 24-bit mantissa to integer position for unbiased exponent E,
// producing the integer magnitude and the guard/sticky bits of what fell off.
module float_align_shifter (
  input  logic        [23:0] mant,
  input  logic signed [8:0]  unbiasedExp,
  output logic        [31:0] magnitude,
  output logic               guard,
  output logic               sticky
);

  logic [47:0] shifted;
  logic [3:0]  leftAmt;
  logic [4:0]  rightAmt;

  always_comb begin
    magnitude = '0;
    guard     = 1'b0;
    sticky    = 1'b0;
    leftAmt   = 4'(unbiasedExp - 9'sd23);
    rightAmt  = 5'(9'sd23 - unbiasedExp);
    shifted   = {mant, 24'd0} >> rightAmt;
    // E up to 31 is handled here so that -2^31 lands on 0x80000000 directly.
    if (unbiasedExp >= 9'sd23) begin
      magnitude = {8'd0, mant} << leftAmt;
    end else if (unbiasedExp >= 9'sd0) begin
      magnitude = {8'd0, shifted[47:24]};
      guard     = shifted[23];
      sticky    = |shifted[22:0];
    end else if (unbiasedExp == -9'sd1) begin
      guard  = 1'b1;
      sticky = |mant[22:0];
    end else begin
      sticky = 1'b1;
    end
  end

endmodule

// File: rtl/float_to_int.sv
// Two-stage valid/ready pipeline converting IEEE single floats to signed 32-bit
// integers with per-transaction RTZ/RNE rounding and invalid/inexact flags.
module float_to_int
  import fp_pkg::*;
#(
  parameter bit PIPE_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_float,
  input  logic        in_rnd_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_int,
  output logic        out_invalid,
  output logic        out_inexact
);

  // Handshake: a stage transfers on a clk edge where its valid && ready are
  // both high; a stage loads when empty or when its contents leave this cycle.
  logic [7:0]         expField;
  logic [22:0]        fracField;
  logic signed [8:0]  unbiasedExp;
  logic [31:0]        shMag;
  logic               shGuard;
  logic               shSticky;
  fp_class_t          inClass;
  align_t             s1Next;
  align_t             s1Q;
  logic               s1Valid;
  logic               s1En;
  logic               stage2Ready;
  logic               roundUp;
  logic [31:0]        rounded;
  logic [31:0]        resInt;
  logic               resInvalid;
  logic               resInexact;

  assign expField    = in_float[30:23];
  assign fracField   = in_float[22:0];
  assign unbiasedExp = $signed({1'b0, expField}) - $signed(9'(FP_BIAS));

  float_align_shifter uAlign (
    .mant        ({1'b1, fracField}),
    .unbiasedExp (unbiasedExp),
    .magnitude   (shMag),
    .guard       (shGuard),
    .sticky      (shSticky)
  );

  always_comb begin
    inClass = FP_NORMAL;
    if (expField == 8'd0) begin
      inClass = FP_ZERO;
    end else if (expField == 8'(FP_EXP_MAX)) begin
      inClass = (|fracField) ? FP_NAN : FP_INF;
    end else if (unbiasedExp >= 9'sd31 && in_float != FP_NEG_2POW31) begin
      inClass = FP_OVF;
    end
  end

  // Denormals collapse to zero magnitude; a nonzero fraction only marks inexact.
  always_comb begin
    s1Next.sign      = in_float[31];
    s1Next.magnitude = shMag;
    s1Next.guard     = shGuard;
    s1Next.sticky    = shSticky;
    s1Next.cls       = inClass;
    s1Next.rndMode   = rnd_mode_t'(in_rnd_mode);
    if (inClass == FP_ZERO) begin
      s1Next.magnitude = '0;
      s1Next.guard     = 1'b0;
      s1Next.sticky    = |fracField;
    end
  end

  assign s1En     = !s1Valid || stage2Ready;
  assign in_ready = s1En;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1Valid <= 1'b0;
      s1Q     <= '0;
    end else if (s1En) begin
      s1Valid <= in_valid;
      if (in_valid) s1Q <= s1Next;
    end
  end

  always_comb begin
    roundUp    = (s1Q.rndMode == RND_RNE) && s1Q.guard && (s1Q.sticky || s1Q.magnitude[0]);
    rounded    = s1Q.magnitude + {31'd0, roundUp};
    resInt     = s1Q.sign ? (~rounded + 32'd1) : rounded;
    resInvalid = 1'b0;
    resInexact = s1Q.guard || s1Q.sticky;
    case (s1Q.cls)
      FP_NAN: begin
        resInt     = INT_MIN;
        resInvalid = 1'b1;
        resInexact = 1'b0;
      end
      FP_INF, FP_OVF: begin
        resInt     = s1Q.sign ? INT_MIN : INT_MAX;
        resInvalid = 1'b1;
        resInexact = 1'b0;
      end
      default: ;
    endcase
  end

  generate
    if (PIPE_OUT) begin : gOutReg
      logic s2Valid;

      assign stage2Ready = !s2Valid || out_ready;
      assign out_valid   = s2Valid;

      always_ff @(posedge clk) begin
        if (!reset) begin
          s2Valid     <= 1'b0;
          out_int     <= '0;
          out_invalid <= 1'b0;
          out_inexact <= 1'b0;
        end else if (stage2Ready) begin
          s2Valid <= s1Valid;
          if (s1Valid) begin
            out_int     <= resInt;
            out_invalid <= resInvalid;
            out_inexact <= resInexact;
          end
        end
      end
    end else begin : gOutComb
      assign stage2Ready = out_ready;
      assign out_valid   = s1Valid;
      assign out_int     = resInt;
      assign out_invalid = resInvalid;
      assign out_inexact = resInexact;
    end
  endgenerate

endmodule

// File: doc/float_to_int.md
Name: float_to_int

Overview:
- Pipelined IEEE-754 single-precision to signed 32-bit integer converter.
- It is the inverse path of the integer-to-float converter and consumes float results produced by it.
- It sits downstream in the FP datapath and uses a valid/ready stream interface on both input and output, so it can absorb backpressure.
- Rounding mode is selected per transaction; invalid and inexact flags travel with each result.

Parameters:
- PIPE_OUT, 1, 1 = output register stage present (latency 2); 0 = stage-2 logic drives outputs combinationally from the stage-1 register (latency 1).

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 clears state on the next clk edge)
- in_valid  input  1  upstream has a transaction
- in_ready  output  1  block accepts the transaction this cycle
- in_float  input  32  IEEE single {sign, exp[7:0], frac[22:0]}
- in_rnd_mode  input  1  0 = round toward zero (truncate), 1 = round to nearest even; captured with in_float
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_int  output  32  signed two's-complement result
- out_invalid  output  1  NaN, infinity, or out-of-range input
- out_inexact  output  1  discarded fraction bits were nonzero (never set together with invalid)

Behaviour:
- Reset (reset==0 at a clk edge): all stage valid bits cleared; out_valid=0, out_int=0, out_invalid=0, out_inexact=0.
  - in_ready is 1 in the first cycle after reset.
  - A reset mid-operation drops in-flight transactions silently.
- Handshake: a transfer occurs on a clk edge where valid&&ready.
  - Each stage register loads when it is empty or its contents transfer out this cycle: stage_en = !stage_valid || next_ready.
  - in_ready = stage-1 enable. It may depend combinationally on out_ready; there is no skid buffer.
  - Payload is held stable while out_valid && !out_ready.
  - Full throughput is one transaction per cycle. Simultaneous accept and emit in the same cycle is legal.
- Latency: in accept edge to out_valid is 2 edges (PIPE_OUT=1) or 1 edge (PIPE_OUT=0).
- Stage 1 (decode/align):
  - E = exp - 127, computed signed 9-bit; mant = {1, frac} for 24 bits.
  - Class decode:
    - zero: exp==0 (denormals are treated as zero magnitude; inexact=1 if frac!=0).
    - nan: exp==255, frac!=0.
    - inf: exp==255, frac==0.
  - E>=31: overflow, except the exact input 0xCF000000, which is legal and gives 0x80000000.
  - 23<=E<=30: magnitude = mant << (E-23); guard=0, sticky=0.
  - 0<=E<=22: magnitude = mant >> (23-E); guard = last bit shifted out; sticky = OR of the remaining shifted-out bits.
  - E<0: magnitude=0.
    - E==-1: guard=1, sticky=|frac.
    - E<=-2: guard=0, sticky=1.
  - Registered: sign, magnitude[31:0], guard, sticky, class bits, rnd_mode.
- Stage 2 (round/sign/saturate):
  - RNE increments magnitude when guard && (sticky || magnitude[0]). RTZ never increments.
  - After rounding, result = sign ? -magnitude : magnitude. Rounding cannot exceed 2^31-1 because the largest float below 2^31 is an integer.
  - inexact = guard || sticky (or the denormal rule), and 0 when invalid.
  - Invalid results:
    - NaN: 0x80000000.
    - +inf or positive overflow: 0x7FFFFFFF.
    - -inf or negative overflow: 0x80000000.
  - Zero input (±0) gives 0x00000000 with no flags.

Decomposition:
- Shared package fp_pkg holds:
  - constants FP_BIAS=127, FP_EXP_MAX=255, INT_MAX=32'h7FFFFFFF, INT_MIN=32'h80000000;
  - enum fp_class_t {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN, FP_OVF};
  - rounding-mode enum rnd_mode_t {RND_RTZ, RND_RNE}.
- One sub-module, float_align_shifter: combinational, 24-bit mant plus signed E in; 32-bit magnitude, guard and sticky out. It is instantiated in stage 1.

Test Plan:
- 0x3FC00000 (1.5): RTZ gives 0x00000001 with inexact=1; RNE gives 0x00000002 with inexact=1.
- 0x40200000 (2.5) RNE gives 2; 0xC0600000 (-3.5) RNE gives 0xFFFFFFFC (-4); 0x3F000000 (0.5) RNE gives 0 with inexact=1.
- 0xCF000000 (-2^31) gives 0x80000000 with no flags; 0x4F000000 (+2^31) gives 0x7FFFFFFF with invalid=1; 0x7FC00000 (NaN) gives 0x80000000 with invalid=1; 0xFF800000 (-inf) gives 0x80000000 with invalid=1.
- Streaming 8 back-to-back inputs with out_ready=1: in_ready stays 1, and outputs appear in order at fixed latency 2 with no gaps.
- Streaming with out_ready=0 for 5 cycles mid-burst: in_ready drops once both stages are full; the held out_int stays stable; no transaction is lost or duplicated after release.
- reset driven 0 for one edge while 2 transactions are in flight: out_valid=0 next cycle, neither transaction appears, in_ready=1.
